// File: rtl/bank_frame_reader_pkg.sv
// Shared types and latency constants for the bank frame reader.
// BANK_FRAME_READER_OREG_EN selects the registered bank output (two-cycle read latency).
package bank_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

`ifdef BANK_FRAME_READER_OREG_EN
  localparam int READ_LATENCY = 2;
`else
  localparam int READ_LATENCY = 1;
`endif

  // One extra slot lets the stream run at full rate while a read is returning.
  localparam int FIFO_DEPTH = READ_LATENCY + 1;

  function automatic int calc_addr_w(input int addr_count);
    return (addr_count > 1) ? $clog2(addr_count) : 1;
  endfunction

endpackage

// File: rtl/bank_skid_fifo.sv
// Small synchronous FIFO with occupancy count; absorbs bank read returns
// while the downstream stream is stalled.
module bank_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bank_frame_reader.sv
// Walks the frame bank read port and streams each address as one multi-lane beat.
// Define BANK_FRAME_READER_OREG_EN when the bank output register is used (adds O_oce).
module bank_frame_reader
  import bank_frame_reader_pkg::*;
#(
  parameter int BYTES_PER_BLOCK = 2250,
  parameter int BLOCK_COUNT     = 2,
  parameter int DATA_WIDTH_B    = 8,
  parameter int ADDR_COUNT      = BYTES_PER_BLOCK * 8 / DATA_WIDTH_B,
  parameter int ADDR_W          = calc_addr_w(ADDR_COUNT)
) (
  input  logic                                I_clk,
  input  logic                                I_rst_n,
  input  logic                                I_start,
  input  logic                                I_abort,
  output logic                                O_ceb,
  output logic [BLOCK_COUNT*ADDR_W-1:0]       O_adb_flat,
  input  logic [BLOCK_COUNT*DATA_WIDTH_B-1:0] I_dout_flat,
  output logic                                O_valid,
  input  logic                                I_ready,
  output logic [BLOCK_COUNT*DATA_WIDTH_B-1:0] O_data,
  output logic                                O_last,
  output logic                                O_busy,
  output logic                                O_done,
  output logic [1:0]                          O_state
`ifdef BANK_FRAME_READER_OREG_EN
  ,
  output logic                                O_oce
`endif
);

  // Stream handshake: a beat moves when O_valid && I_ready on a rising edge;
  // O_valid never waits on I_ready, and O_data/O_last hold until accepted.
  localparam int DW = BLOCK_COUNT * DATA_WIDTH_B;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ADDR_COUNT - 1);
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_READ  = ST_READ;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;

  logic [1:0]              state;
  logic [ADDR_W-1:0]       addr;
  logic                    done_q;
  logic [READ_LATENCY-1:0] ret_vld;
  logic [READ_LATENCY-1:0] ret_last;
  logic                    issue;
  logic                    pop;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [DW:0]             fifo_head;
  int                      occ;

  // Occupancy after this cycle's pop: FIFO entries plus reads still in the bank.
  always_comb begin
    occ = int'(fifo_count) - int'(pop);
    for (int k = 0; k < READ_LATENCY; k++) occ += int'(ret_vld[k]);
  end

  assign pop   = O_valid && I_ready;
  assign issue = (state == S_READ) && !I_abort && (occ < FIFO_DEPTH);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state  <= S_IDLE;
      addr   <= '0;
      done_q <= 1'b0;
    end else if (I_abort) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (I_start && !done_q) begin
            state <= S_READ;
            addr  <= '0;
          end
        end
        S_READ: begin
          if (issue) begin
            if (addr == LAST_ADDR) state <= S_DRAIN;
            else addr <= addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (pop && O_last) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // In-flight tracker: clearing a slot on abort makes its bank return vanish.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ret_vld  <= '0;
      ret_last <= '0;
    end else if (I_abort) begin
      ret_vld  <= '0;
      ret_last <= '0;
    end else begin
      ret_vld[0]  <= issue;
      ret_last[0] <= issue && (addr == LAST_ADDR);
      for (int k = 1; k < READ_LATENCY; k++) begin
        ret_vld[k]  <= ret_vld[k-1];
        ret_last[k] <= ret_last[k-1];
      end
    end
  end

  bank_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .flush (I_abort),
    .push  (ret_vld[READ_LATENCY-1]),
    .din   ({ret_last[READ_LATENCY-1], I_dout_flat}),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign O_ceb      = issue;
  assign O_adb_flat = {BLOCK_COUNT{addr}};
  assign O_valid    = !fifo_empty;
  assign O_data     = fifo_head[DW-1:0];
  assign O_last     = O_valid && fifo_head[DW];
  assign O_busy     = (state != S_IDLE);
  assign O_done     = done_q;
  assign O_state    = state;
`ifdef BANK_FRAME_READER_OREG_EN
  assign O_oce      = (state != S_IDLE);
`endif

endmodule

// File: tb/tb_bank_frame_reader.sv
// Self-checking bench for bank_frame_reader: bank model, random backpressure,
// and a beat-level scoreboard built from the frame's address/byte rules.
module tb_bank_frame_reader;

  localparam int BPB = 4;
  localparam int BC  = 2;
  localparam int DWB = 8;
  localparam int N   = BPB * 8 / DWB;
  localparam int AW  = $clog2(N);
  localparam int DW  = BC * DWB;
`ifdef BANK_FRAME_READER_OREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int D = L + 1;

  logic I_clk = 1'b0, I_rst_n = 1'b0, I_start = 1'b0, I_abort = 1'b0, I_ready = 1'b0;
  logic O_ceb, O_valid, O_last, O_busy, O_done;
  logic [BC*AW-1:0] O_adb_flat;
  logic [DW-1:0]    I_dout_flat = '0;
  logic [DW-1:0]    O_data;
  logic [1:0]       O_state;
`ifdef BANK_FRAME_READER_OREG_EN
  logic             O_oce;
`endif

  bank_frame_reader #(
    .BYTES_PER_BLOCK (BPB),
    .BLOCK_COUNT     (BC),
    .DATA_WIDTH_B    (DWB)
  ) dut (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_start     (I_start),
    .I_abort     (I_abort),
    .O_ceb       (O_ceb),
    .O_adb_flat  (O_adb_flat),
    .I_dout_flat (I_dout_flat),
    .O_valid     (O_valid),
    .I_ready     (I_ready),
    .O_data      (O_data),
    .O_last      (O_last),
    .O_busy      (O_busy),
    .O_done      (O_done),
    .O_state     (O_state)
`ifdef BANK_FRAME_READER_OREG_EN
    ,
    .O_oce       (O_oce)
`endif
  );

  // ---------------- clock ----------------
  always #5 I_clk = ~I_clk;

  // ---------------- bank model ----------------
  function automatic logic [DW-1:0] bank_word(input logic [BC*AW-1:0] adb);
    logic [DW-1:0] w;
    for (int i = 0; i < BC; i++) w[i*DWB +: DWB] = 8'(128 * i + int'(adb[i*AW +: AW]));
    return w;
  endfunction

`ifdef BANK_FRAME_READER_OREG_EN
  logic [DW-1:0] bank_stage = '0;
  always @(posedge I_clk) begin
    if (O_ceb) bank_stage <= bank_word(O_adb_flat);
    if (O_oce) I_dout_flat <= bank_stage;
  end
`else
  always @(posedge I_clk) if (O_ceb) I_dout_flat <= bank_word(O_adb_flat);
`endif

  // ---------------- reference model / scoreboard ----------------
  logic [DW:0] exp_q[$];
  int          xfer_cyc[$];
  int          compared = 0, mismatched = 0;
  int          issued, accepted, exp_addr, cyc, n_ceb, start_cyc, first_valid_cyc;
  bit          busy_m, done_m, stalled, abort_prev, seen_done;
  logic [DW:0] hold;

  function automatic logic [DW:0] exp_beat(input int a);
    logic [DW:0] b;
    b[DW] = (a == N - 1);
    for (int i = 0; i < BC; i++) b[i*DWB +: DWB] = 8'(128 * i + a);
    return b;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    xfer_cyc.delete();
    busy_m = 0; done_m = 0; stalled = 0; abort_prev = 0; seen_done = 0;
    issued = 0; accepted = 0; exp_addr = 0; n_ceb = 0;
    start_cyc = 0; first_valid_cyc = -1;
  endtask

  // One clock: sample at negedge+1, check, update the model, return at next negedge.
  task automatic cycle();
    logic [DW:0] want;
    bit xfer, done_next;
    #1;
    cyc++;
    compared += 2;
    if (O_busy !== busy_m) begin
      mismatched++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, O_busy, busy_m);
    end
    if (O_done !== done_m) begin
      mismatched++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, O_done, done_m);
    end
    if (O_done === 1'b1) seen_done = 1;
`ifdef BANK_FRAME_READER_OREG_EN
    compared++;
    if (O_oce !== busy_m) begin
      mismatched++; $display("FAIL oce cyc=%0d got=%b exp=%b", cyc, O_oce, busy_m);
    end
`endif
    if (!busy_m || abort_prev) begin
      compared++;
      if (O_valid !== 1'b0 || O_ceb !== 1'b0) begin
        mismatched++; $display("FAIL idle_quiet cyc=%0d valid=%b ceb=%b exp=0/0", cyc, O_valid, O_ceb);
      end
    end
    xfer = (O_valid === 1'b1) && I_ready;
    if (O_ceb === 1'b1 && busy_m) begin
      n_ceb++;
      for (int i = 0; i < BC; i++) begin
        compared++;
        if (exp_addr >= N || O_adb_flat[i*AW +: AW] !== AW'(exp_addr)) begin
          mismatched++;
          $display("FAIL addr cyc=%0d lane=%0d got=%0d exp=%0d", cyc, i, O_adb_flat[i*AW +: AW], exp_addr);
        end
      end
      compared++;
      if (issued - accepted - int'(xfer) >= D) begin
        mismatched++;
        $display("FAIL credit cyc=%0d outstanding=%0d limit<%0d", cyc, issued - accepted - int'(xfer), D);
      end
      issued++;
      exp_addr++;
    end
    if (stalled) begin
      compared++;
      if (O_valid !== 1'b1 || {O_last, O_data} !== hold) begin
        mismatched++;
        $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, O_valid, {O_last, O_data}, hold);
      end
    end
    if (O_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    done_next = 0;
    if (xfer) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++; $display("FAIL beat cyc=%0d got=%h exp=none", cyc, {O_last, O_data});
      end else begin
        want = exp_q.pop_front();
        if ({O_last, O_data} !== want) begin
          mismatched++; $display("FAIL beat cyc=%0d got=%h exp=%h", cyc, {O_last, O_data}, want);
        end
        done_next = want[DW];
      end
      xfer_cyc.push_back(cyc);
      accepted++;
    end
    stalled    = (O_valid === 1'b1) && !I_ready;
    hold       = {O_last, O_data};
    abort_prev = I_abort;
    if (I_abort) begin
      busy_m = 0; exp_q.delete(); issued = 0; accepted = 0; stalled = 0; done_next = 0;
    end else if (I_start && !busy_m && !done_m) begin
      busy_m = 1;
      exp_q.delete();
      for (int a = 0; a < N; a++) exp_q.push_back(exp_beat(a));
      exp_addr = 0; issued = 0; accepted = 0; n_ceb = 0;
      start_cyc = cyc; first_valid_cyc = -1; xfer_cyc.delete();
    end else if (done_next) begin
      busy_m = 0;
    end
    done_m = done_next;
    @(negedge I_clk);
  endtask

  task automatic start_frame();
    I_start = 1; cycle(); I_start = 0;
    seen_done = 0;
  endtask

  task automatic run_to_done(input int budget, input string name);
    for (int k = 0; k < budget && !seen_done; k++) cycle();
    compared++;
    if (!seen_done) begin
      mismatched++; $display("FAIL %s_timeout done=0 exp=1 within %0d cycles", name, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    I_rst_n = 0;
    @(negedge I_clk); @(negedge I_clk);
    compared++;
    if ({O_ceb, O_adb_flat, O_valid, O_data, O_last, O_busy, O_done} !== '0) begin
      mismatched++;
      $display("FAIL reset ceb=%b adb=%h valid=%b data=%h last=%b busy=%b done=%b exp all 0",
               O_ceb, O_adb_flat, O_valid, O_data, O_last, O_busy, O_done);
    end
    I_rst_n = 1;
    model_reset();
    cycle(); cycle();
  endtask

  task automatic test_ready_high();
    I_ready = 1;
    start_frame();
    run_to_done(40, "ready_high");
    // Rise edge counted from the edge that samples I_start.
    compared++;
    if (first_valid_cyc - start_cyc - 1 != L + 1) begin
      mismatched++;
      $display("FAIL first_valid_latency got=%0d exp=%0d", first_valid_cyc - start_cyc - 1, L + 1);
    end
    compared++;
    if (xfer_cyc.size() != N || xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0] != N - 1) begin
      mismatched++; $display("FAIL back_to_back beats=%0d exp=%0d consecutive", xfer_cyc.size(), N);
    end
    cycle(); cycle();
  endtask

  task automatic test_ready_pattern();
    bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    I_ready = pat[0];
    start_frame();
    for (int k = 1; k < 60 && !seen_done; k++) begin
      I_ready = (k < 7) ? pat[k] : 1'b1;
      cycle();
    end
    compared++;
    if (!seen_done || n_ceb != N || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL ready_pattern done=%b ceb=%0d left=%0d exp=1/%0d/0", seen_done, n_ceb, exp_q.size(), N);
    end
    cycle();
  endtask

  task automatic test_ready_low();
    I_ready = 0;
    start_frame();
    for (int k = 0; k < 12; k++) cycle();
    compared++;
    if (n_ceb != D) begin
      mismatched++; $display("FAIL stalled_issues got=%0d exp=%0d", n_ceb, D);
    end
    I_ready = 1;
    run_to_done(40, "ready_low");
    compared++;
    if (n_ceb != N) begin
      mismatched++; $display("FAIL resumed_issues got=%0d exp=%0d", n_ceb, N);
    end
    cycle();
  endtask

  task automatic test_abort();
    I_ready = 1;
    start_frame();
    for (int k = 0; k < 20 && accepted < 2; k++) cycle();
    I_ready = 0; I_abort = 1; cycle(); I_abort = 0;
    compared++;
    if (O_valid !== 1'b0 || O_ceb !== 1'b0 || O_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_flush valid=%b ceb=%b busy=%b exp 0/0/0", O_valid, O_ceb, O_busy);
    end
    for (int k = 0; k < 5; k++) cycle();
    compared++;
    if (seen_done) begin
      mismatched++; $display("FAIL abort_done got=1 exp=0");
    end
    I_ready = 1;
    start_frame();
    run_to_done(40, "after_abort");
    cycle();
  endtask

  task automatic test_start_ignored();
    I_ready = 1;
    start_frame();
    for (int k = 0; k < 20; k++) begin
      I_start = (k == 2) || done_m;
      cycle();
    end
    I_start = 0;
    compared++;
    if (!seen_done || n_ceb != N) begin
      mismatched++; $display("FAIL start_ignored done=%b ceb=%0d exp=1/%0d", seen_done, n_ceb, N);
    end
  endtask

  task automatic test_random();
    int abort_at;
    bit aborted;
    for (int f = 0; f < 6; f++) begin
      abort_at = (f % 3 == 2) ? int'($urandom_range(2, 3 * N)) : -1;
      aborted  = 0;
      I_ready  = 1'($urandom_range(0, 1));
      start_frame();
      for (int k = 0; k < 300 && !seen_done && !aborted; k++) begin
        I_ready = ($urandom_range(0, 3) != 0);
        if (k == abort_at) begin
          I_abort = 1; cycle(); I_abort = 0; aborted = 1;
        end else begin
          cycle();
        end
      end
      compared++;
      if (!seen_done && !aborted) begin
        mismatched++; $display("FAIL random_frame%0d_timeout done=0 exp=1", f);
      end
      I_ready = 0;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) cycle();
    end
  endtask

  task automatic test_reset_mid_frame();
    I_ready = 0;
    start_frame();
    for (int k = 0; k < 4; k++) cycle();
    #2 I_rst_n = 0;
    #1;
    compared++;
    if ({O_ceb, O_adb_flat, O_valid, O_data, O_last, O_busy, O_done} !== '0) begin
      mismatched++;
      $display("FAIL async_reset ceb=%b adb=%h valid=%b data=%h busy=%b exp all 0",
               O_ceb, O_adb_flat, O_valid, O_data, O_busy);
    end
    @(negedge I_clk);
    I_rst_n = 1;
    model_reset();
    cycle();
    I_ready = 1;
    start_frame();
    run_to_done(40, "after_reset");
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_ready_high();
    test_ready_pattern();
    test_ready_low();
    test_abort();
    test_start_ignored();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
